// File: rtl/lif_synapse.sv
// lif_synapse -- synaptic input stage feeding the lif neuron current input.
//
// Each of N_SYN binary spike lines selects a programmable signed 8-bit
// weight. The selected weights are summed in one registered stage (psum_q).
// The sum is then integrated into a leaky, saturating 8-bit accumulator
// (acc_q), which drives the current output directly.
//
// Optional build macro: SYN_DECAY_PRESCALE_EN
//   When defined, a free-running PRESCALE_BITS counter gates the leak so it
//   is applied only on edges where the counter is all-ones. When undefined,
//   the leak is applied on every edge and no counter exists.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset; clears all state
//   spike_in  in   [N_SYN]  presynaptic spikes, sampled every rising edge
//   wt_we     in   weight write enable
//   wt_addr   in   [3]  weight index; indices >= N_SYN are ignored
//   wt_data   in   [8]  signed weight value
//   current   out  [8]  unsigned synaptic current (registered)
//   sat       out  high for each cycle in which current was clamped at 255
module lif_synapse #(
   parameter int unsigned N_SYN         = 4,
   parameter int unsigned DECAY_SHIFT   = 3,
   parameter int unsigned PRESCALE_BITS = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_SYN-1:0] spike_in,
   input  logic             wt_we,
   input  logic [2:0]       wt_addr,
   input  logic [7:0]       wt_data,
   output logic [7:0]       current,
   output logic             sat
);

   // Partial-sum width: 8-bit weight, log2(N_SYN) growth bits, one spare.
   localparam int unsigned PSUM_W = 8 + $clog2(N_SYN) + 1;
   // Accumulator update width: covers 255 + N_SYN*127 and -(N_SYN*128) signed.
   localparam int unsigned NXT_W  = 13;
   localparam logic signed [NXT_W-1:0] ACC_MAX = 255;

   if (N_SYN < 2 || N_SYN > 8 || DECAY_SHIFT < 1 || DECAY_SHIFT > 7 ||
       PRESCALE_BITS < 1) begin : g_bad_params
      $error("lif_synapse: parameter out of range");
   end

   logic signed [7:0]        wt_q [N_SYN];
   logic signed [PSUM_W-1:0] psum_q, psum_d;
   logic [7:0]               acc_q, acc_d;
   logic                     sat_q, sat_d;
   logic                     leak_en;
   logic [7:0]               leak;
   logic signed [NXT_W-1:0]  acc_ext, leak_ext, psum_ext, nxt;

   // ---------------------------------------------------------------------
   // Leak gating
   // ---------------------------------------------------------------------
`ifdef SYN_DECAY_PRESCALE_EN
   logic [PRESCALE_BITS-1:0] pre_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   assign leak_en = (pre_q == '1);
`else
   assign leak_en = 1'b1;
`endif

   // ---------------------------------------------------------------------
   // Stage 1: weighted spike sum (reads the pre-write weight file)
   // ---------------------------------------------------------------------
   always_comb begin
      psum_d = '0;
      for (int unsigned i = 0; i < N_SYN; i++) begin
         if (spike_in[i]) begin
            psum_d = psum_d + PSUM_W'(wt_q[i]);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: leaky saturating accumulator
   // ---------------------------------------------------------------------
   always_comb begin
      leak = '0;
      if (leak_en) begin
         leak = acc_q >> DECAY_SHIFT;
         // A small non-zero accumulator still leaks by one so it reaches 0.
         if (acc_q != '0 && leak == '0) begin
            leak = 8'd1;
         end
      end

      acc_ext  = signed'(NXT_W'(acc_q));
      leak_ext = signed'(NXT_W'(leak));
      psum_ext = NXT_W'(psum_q);
      nxt      = acc_ext - leak_ext + psum_ext;

      if (nxt > ACC_MAX) begin
         acc_d = 8'hFF;
         sat_d = 1'b1;
      end else if (nxt[NXT_W-1]) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else begin
         acc_d = nxt[7:0];
         sat_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < N_SYN; i++) begin
            wt_q[i] <= '0;
         end
         psum_q <= '0;
         acc_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         // Out-of-range addresses match no index and are dropped.
         for (int unsigned i = 0; i < N_SYN; i++) begin
            if (wt_we && wt_addr == 3'(i)) begin
               wt_q[i] <= wt_data;
            end
         end
         psum_q <= psum_d;
         acc_q  <= acc_d;
         sat_q  <= sat_d;
      end
   end

   assign current = acc_q;
   assign sat     = sat_q;

endmodule
